// File: rtl/cpu_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cpu_bus_master                                                   |
// | Brief   : Single-request CPU master that serialises onto the C1/A1/D1 bus. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module cpu_bus_master #(
  parameter int CACHE_TAG_SIZE    = 10,
  parameter int CACHE_SET_SIZE    = 5,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int ADDR1_BUS_SIZE    = 15,
  parameter int DATA_BUS_SIZE     = 16,
  parameter int MAX_XFER_BITS     = 32,
  parameter int TIMEOUT           = 64
) (
  input  logic                                                        CLK,
  input  logic                                                        RESET,
  input  logic                                                        req_valid,
  output logic                                                        req_ready,
  input  logic [2:0]                                                  req_cmd,
  input  logic [CACHE_TAG_SIZE+CACHE_SET_SIZE+CACHE_OFFSET_SIZE-1:0]  req_addr,
  input  logic [MAX_XFER_BITS-1:0]                                    req_wdata,
  output logic                                                        rsp_valid,
  output logic                                                        rsp_err,
  output logic [MAX_XFER_BITS-1:0]                                    rsp_rdata,
  inout  wire  [ADDR1_BUS_SIZE-1:0]                                   A1,
  inout  wire  [DATA_BUS_SIZE-1:0]                                    D1,
  inout  wire  [2:0]                                                  C1
);

  localparam int c_addr_w    = CACHE_TAG_SIZE + CACHE_SET_SIZE + CACHE_OFFSET_SIZE;
  localparam int c_dbw       = DATA_BUS_SIZE;
  localparam int c_max_beats = (MAX_XFER_BITS + c_dbw - 1) / c_dbw;
  localparam int c_buf_w     = c_max_beats * c_dbw;
  localparam int c_tmo_w     = $clog2(TIMEOUT + 2);

  localparam logic [2:0] c_cmd_nop     = 3'd0;
  localparam logic [2:0] c_cmd_read8   = 3'd1;
  localparam logic [2:0] c_cmd_read16  = 3'd2;
  localparam logic [2:0] c_cmd_read32  = 3'd3;
  localparam logic [2:0] c_cmd_write8  = 3'd5;
  localparam logic [2:0] c_cmd_write16 = 3'd6;
  localparam logic [2:0] c_cmd_write32 = 3'd7;
  localparam logic [2:0] c_cmd_resp    = 3'd7;

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_addr_hi = 3'd1;
  localparam logic [2:0] c_st_addr_lo = 3'd2;
  localparam logic [2:0] c_st_wdata   = 3'd3;
  localparam logic [2:0] c_st_release = 3'd4;
  localparam logic [2:0] c_st_wait    = 3'd5;
  localparam logic [2:0] c_st_rdata   = 3'd6;
  localparam logic [2:0] c_st_resp    = 3'd7;

  logic [2:0]               r_state;
  logic [2:0]               r_cmd;
  logic [c_addr_w-1:0]      r_addr;
  logic [c_buf_w-1:0]       r_wshift;
  logic [c_buf_w-1:0]       r_rbuf;
  logic [2:0]               r_beats;
  logic [2:0]               r_beat;
  logic [c_tmo_w-1:0]       r_tmo;
  logic                     r_err;
  logic [MAX_XFER_BITS-1:0] r_rdata_hold;

  logic                      w_is_read;
  logic                      w_is_write;
  logic                      w_req_bad;
  logic                      w_timeout_hit;
  logic                      w_c1_oe;
  logic                      w_a1_oe;
  logic                      w_d1_oe;
  logic [ADDR1_BUS_SIZE-1:0] w_a1;
  logic [MAX_XFER_BITS-1:0]  w_rdata_final;

  function automatic int f_size(input logic [2:0] cmd);
    case (cmd)
      c_cmd_read8,  c_cmd_write8:  f_size = 8;
      c_cmd_read16, c_cmd_write16: f_size = 16;
      c_cmd_read32, c_cmd_write32: f_size = 32;
      default:                     f_size = 0;
    endcase
  endfunction

  function automatic logic [2:0] f_beats(input int size);
    if (size <= c_dbw) f_beats = 3'd1;
    else               f_beats = 3'((size + c_dbw - 1) / c_dbw);
  endfunction

  assign w_is_read     = (r_cmd == c_cmd_read8) || (r_cmd == c_cmd_read16) || (r_cmd == c_cmd_read32);
  assign w_is_write    = (r_cmd == c_cmd_write8) || (r_cmd == c_cmd_write16) || (r_cmd == c_cmd_write32);
  assign w_req_bad     = (req_cmd == c_cmd_nop) || (f_size(req_cmd) > MAX_XFER_BITS);
  assign w_timeout_hit = (TIMEOUT != 0) && (r_tmo == c_tmo_w'(TIMEOUT - 1));

  assign w_c1_oe = (r_state == c_st_addr_hi) || (r_state == c_st_addr_lo) || (r_state == c_st_wdata);
  assign w_a1_oe = (r_state == c_st_addr_hi) || (r_state == c_st_addr_lo);
  assign w_d1_oe = w_is_write && ((r_state == c_st_addr_hi) || (r_state == c_st_wdata) ||
                                  ((r_state == c_st_addr_lo) && (r_beats > 3'd1)));

  always_comb begin
    w_a1 = '0;
    if (r_state == c_st_addr_hi) w_a1 = ADDR1_BUS_SIZE'(r_addr[c_addr_w-1:CACHE_OFFSET_SIZE]);
    else                         w_a1 = ADDR1_BUS_SIZE'(r_addr[CACHE_OFFSET_SIZE-1:0]);
  end

  assign C1 = w_c1_oe ? r_cmd : 'z;
  assign A1 = w_a1_oe ? w_a1 : 'z;
  assign D1 = w_d1_oe ? r_wshift[c_dbw-1:0] : 'z;

  // Read data is zero-extended to the transfer size; errors and non-reads return zero.
  always_comb begin
    w_rdata_final = '0;
    if (w_is_read && !r_err) begin
      for (int i = 0; i < MAX_XFER_BITS; i++) begin
        if (i < f_size(r_cmd)) w_rdata_final[i] = r_rbuf[i];
      end
    end
  end

  assign req_ready = (r_state == c_st_idle);
  assign rsp_valid = (r_state == c_st_resp);
  assign rsp_err   = (r_state == c_st_resp) && r_err;
  assign rsp_rdata = (r_state == c_st_resp) ? w_rdata_final : r_rdata_hold;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= c_st_idle;
      r_cmd        <= c_cmd_nop;
      r_addr       <= '0;
      r_wshift     <= '0;
      r_rbuf       <= '0;
      r_beats      <= 3'd1;
      r_beat       <= 3'd0;
      r_tmo        <= '0;
      r_err        <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (req_valid) begin
            r_cmd    <= req_cmd;
            r_addr   <= req_addr;
            r_wshift <= c_buf_w'(req_wdata);
            r_beats  <= f_beats(f_size(req_cmd));
            r_err    <= w_req_bad;
            r_state  <= w_req_bad ? c_st_resp : c_st_addr_hi;
          end
        end
        c_st_addr_hi: begin
          r_wshift <= r_wshift >> c_dbw;
          r_state  <= c_st_addr_lo;
        end
        c_st_addr_lo: begin
          r_wshift <= r_wshift >> c_dbw;
          r_beat   <= 3'd2;
          r_state  <= (w_is_write && (r_beats > 3'd2)) ? c_st_wdata : c_st_release;
        end
        c_st_wdata: begin
          r_wshift <= r_wshift >> c_dbw;
          r_beat   <= r_beat + 3'd1;
          if (r_beat == r_beats - 3'd1) r_state <= c_st_release;
        end
        c_st_release: begin
          r_tmo   <= '0;
          r_state <= c_st_wait;
        end
        c_st_wait: begin
          // A response arriving on the timeout cycle takes priority.
          if (C1 == c_cmd_resp) begin
            r_err <= 1'b0;
            if (w_is_read) begin
              r_rbuf[c_dbw-1:0] <= D1;
              r_beat            <= 3'd1;
              r_state           <= (r_beats > 3'd1) ? c_st_rdata : c_st_resp;
            end else begin
              r_state <= c_st_resp;
            end
          end else if (w_timeout_hit) begin
            r_err   <= 1'b1;
            r_state <= c_st_resp;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        c_st_rdata: begin
          r_rbuf[int'(r_beat)*c_dbw +: c_dbw] <= D1;
          r_beat <= r_beat + 3'd1;
          if (r_beat == r_beats - 3'd1) r_state <= c_st_resp;
        end
        c_st_resp: begin
          r_rdata_hold <= w_rdata_final;
          r_state      <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_master.sv
`default_nettype none
// Self-checking bench for cpu_bus_master: directed vector table, hand-written
// reset corner case and randomized requests against a behavioural model.
module tb_cpu_bus_master;

  localparam int TMO = 64;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_cmd = 3'd0;
  logic [18:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  wire  [14:0] A1;
  wire  [15:0] D1;
  wire  [2:0]  C1;

  // Responder side of the shared bus.
  logic        tb_c1_en = 1'b0;
  logic [2:0]  tb_c1 = 3'd0;
  logic        tb_d1_en = 1'b0;
  logic [15:0] tb_d1 = '0;
  assign C1 = tb_c1_en ? tb_c1 : 3'bzzz;
  assign D1 = tb_d1_en ? tb_d1 : 16'hzzzz;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  cpu_bus_master dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .A1        (A1),
    .D1        (D1),
    .C1        (C1)
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [18:0] addr;
    logic [31:0] wd;
    int          delay;      // WAIT cycles before the response; -1 = never
    logic [15:0] rd0;
    logic [15:0] rd1;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  // ---------------- behavioural model ----------------
  function automatic int size_of(input logic [2:0] c);
    case (c)
      3'd1, 3'd5: return 8;
      3'd2, 3'd6: return 16;
      3'd3, 3'd7: return 32;
      default:    return 0;
    endcase
  endfunction

  function automatic int beats_of(input logic [2:0] c);
    int s = size_of(c);
    return (s == 0) ? 1 : (s + 15) / 16;
  endfunction

  function automatic bit is_rd(input logic [2:0] c);
    return (c >= 3'd1) && (c <= 3'd3);
  endfunction

  function automatic bit is_wr(input logic [2:0] c);
    return c >= 3'd5;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [2:0] c, input logic [15:0] r0, input logic [15:0] r1);
    int s = size_of(c);
    logic [31:0] m;
    if (!is_rd(c)) return 32'h0;
    m = (s == 32) ? 32'hFFFF_FFFF : ((32'd1 << s) - 32'd1);
    return {r1, r0} & m;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_free(input logic [15:0] v);
    for (int i = 0; i < 16; i++)
      if (v[i] !== 1'bz && v[i] !== 1'b0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_one(input string name, input bit drv, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (drv ? (act !== exp) : !is_free(act)) begin
      errors++;
      if (drv) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else     $display("FAIL %s: got %0h expected released bus", name, act);
    end
  endtask

  task automatic check_bus(input string ph, input bit c_drv, input logic [2:0] c_exp,
                           input bit a_drv, input logic [14:0] a_exp,
                           input bit d_drv, input logic [15:0] d_exp);
    check_one({ph, " C1"}, c_drv, 16'(C1), 16'(c_exp));
    check_one({ph, " A1"}, a_drv, 16'(A1), 16'(a_exp));
    check_one({ph, " D1"}, d_drv, D1, d_exp);
  endtask

  // One complete request, called and returning on a negedge with the DUT idle.
  task automatic run_txn(input vec_t v, input bit noise, input bit poke);
    int n = beats_of(v.cmd);
    int k = 0;
    check("idle req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_cmd = v.cmd; req_addr = v.addr; req_wdata = v.wd;
    @(negedge CLK);
    req_valid = 1'b0; req_cmd = 3'd0;
    if (v.cmd != 3'd0) begin
      check("busy req_ready", req_ready, 1'b0);
      check_bus("addr_hi", 1'b1, v.cmd, 1'b1, 15'(v.addr >> 4), is_wr(v.cmd), v.wd[15:0]);
      @(negedge CLK);
      check_bus("addr_lo", 1'b1, v.cmd, 1'b1, 15'(v.addr & 19'd15), is_wr(v.cmd) && (n > 1), v.wd[31:16]);
      @(negedge CLK);
      check_bus("release", 1'b0, 3'd0, 1'b0, 15'd0, 1'b0, 16'd0);
      @(negedge CLK);
      while (!((v.delay >= 0 && k == v.delay) || k == TMO)) begin
        check("wait rsp_valid", rsp_valid, 1'b0);
        if (k == 0) check("wait req_ready", req_ready, 1'b0);
        req_valid = poke && (k == 0);
        req_cmd   = 3'd1;
        tb_c1_en  = noise;
        tb_c1     = 3'(k % 7);
        @(negedge CLK);
        k++;
      end
      req_valid = 1'b0; req_cmd = 3'd0; tb_c1_en = 1'b0;
      if (v.delay >= 0 && k == v.delay) begin
        tb_c1_en = 1'b1; tb_c1 = 3'd7; tb_d1_en = 1'b1; tb_d1 = v.rd0;
        @(negedge CLK);
        tb_c1_en = 1'b0;
        if (is_rd(v.cmd) && n > 1) begin
          tb_d1 = v.rd1;
          @(negedge CLK);
        end
        tb_d1_en = 1'b0;
      end
    end
    #1;
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_err", rsp_err, v.exp_err);
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check_bus("resp", 1'b0, 3'd0, 1'b0, 15'd0, 1'b0, 16'd0);
    @(negedge CLK);
    check("rsp pulse end", rsp_valid, 1'b0);
    check("back to idle", req_ready, 1'b1);
    check("rdata hold", rsp_rdata, v.exp_rdata);
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{3'd7, 19'd547,     32'h2505C87C, 2,  16'h0000, 16'h0000, 1'b0, 32'h0000_0000};
    vt[1] = '{3'd3, 19'd547,     32'h0,        2,  16'h1234, 16'hABCD, 1'b0, 32'hABCD_1234};
    vt[2] = '{3'd3, 19'd547,     32'h0,        2,  16'h1234, 16'hABCD, 1'b0, 32'hABCD_1234};
    vt[3] = '{3'd1, 19'd547,     32'h0,        1,  16'h55AA, 16'h0000, 1'b0, 32'h0000_00AA};
    vt[4] = '{3'd4, 19'd35,      32'h0,        0,  16'h0000, 16'h0000, 1'b0, 32'h0000_0000};
    vt[5] = '{3'd0, 19'd100,     32'h0,        0,  16'h0000, 16'h0000, 1'b1, 32'h0000_0000};
    vt[6] = '{3'd2, 19'h01235,   32'h0,        63, 16'hBEEF, 16'h0000, 1'b0, 32'h0000_BEEF};
    vt[7] = '{3'd5, 19'd77,      32'h12345678, -1, 16'h0000, 16'h0000, 1'b1, 32'h0000_0000};
    vt[8] = '{3'd6, 19'h7ABCD,   32'hDEAD9876, 5,  16'h0000, 16'h0000, 1'b0, 32'h0000_0000};

    // Reset state
    @(negedge CLK);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_err", rsp_err, 1'b0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check_bus("reset", 1'b0, 3'd0, 1'b0, 15'd0, 1'b0, 16'd0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("post-reset req_ready", req_ready, 1'b1);
    @(negedge CLK);

    // Directed vectors
    for (int i = 0; i < 9; i++) run_txn(vt[i], 1'b0, (i == 8));

    // Reset asserted during ADDR_LO of a WRITE32 drops it silently
    req_valid = 1'b1; req_cmd = 3'd7; req_addr = 19'd547; req_wdata = 32'h2505C87C;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    check("pre-reset A1", A1, 15'd3);
    RESET = 1'b0;
    #1;
    check_bus("mid reset", 1'b0, 3'd0, 1'b0, 15'd0, 1'b0, 16'd0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("after reset req_ready", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("no rsp after reset", rsp_valid, 1'b0);
    end

    // Randomized requests against the model
    for (int i = 0; i < 40; i++) begin
      vec_t r;
      r.cmd       = 3'($urandom_range(0, 7));
      r.addr      = 19'($urandom);
      r.wd        = $urandom;
      r.delay     = $urandom_range(0, 12);
      r.rd0       = 16'($urandom);
      r.rd1       = 16'($urandom);
      r.exp_err   = (r.cmd == 3'd0);
      r.exp_rdata = model_rdata(r.cmd, r.rd0, r.rd1);
      run_txn(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
